// File: rtl/uart_cmd_parser.sv
// ASCII hex command parser behind the UART receiver: turns "WAADD<EOL>" and
// "RAA<EOL>" lines into one-cycle register write / read-request strobes.
module uart_cmd_parser #(
    parameter int CLK_FREQ       = 25_000_000,
    parameter int TIMEOUT_CYCLES = CLK_FREQ
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    output logic       cmd_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, EOL_WAIT, FLUSH
    } state_t;

    state_t     state, state_nxt;
    logic       is_write, is_write_nxt;
    logic [7:0] addr_sr, addr_sr_nxt;
    logic [7:0] data_sr, data_sr_nxt;
    logic       wr_en_nxt, rd_en_nxt, err_nxt;
    logic       timeout;

    // {valid, nibble}
    function automatic logic [4:0] hex_nib(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39)      return {1'b1, 4'(b - 8'h30)};
        else if (b >= 8'h61 && b <= 8'h66) return {1'b1, 4'(b - 8'h57)};
        else if (b >= 8'h41 && b <= 8'h46) return {1'b1, 4'(b - 8'h37)};
        else                               return 5'd0;
    endfunction

    logic [4:0] hx;
    logic       is_hex, is_eol;
    assign hx     = hex_nib(rx_data);
    assign is_hex = hx[4];
    assign is_eol = (rx_data == 8'h0D) || (rx_data == 8'h0A);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_to
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] idle_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    idle_cnt <= '0;
                else if (rx_valid || state == IDLE || timeout)
                    idle_cnt <= '0;
                else
                    idle_cnt <= idle_cnt + CW'(1);
            end
            assign timeout = (state != IDLE) && (idle_cnt == CW'(TIMEOUT_CYCLES));
        end else begin : g_no_to
            assign timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        state_nxt    = state;
        is_write_nxt = is_write;
        addr_sr_nxt  = addr_sr;
        data_sr_nxt  = data_sr;
        wr_en_nxt    = 1'b0;
        rd_en_nxt    = 1'b0;
        err_nxt      = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == 8'h57 || rx_data == 8'h77) begin
                        is_write_nxt = 1'b1;
                        state_nxt    = ADDR_HI;
                    end else if (rx_data == 8'h52 || rx_data == 8'h72) begin
                        is_write_nxt = 1'b0;
                        state_nxt    = ADDR_HI;
                    end else if (!is_eol) begin
                        err_nxt   = 1'b1;
                        state_nxt = FLUSH;
                    end
                end
                ADDR_HI, ADDR_LO, DATA_HI, DATA_LO: begin
                    if (is_hex) begin
                        case (state)
                            ADDR_HI: begin
                                addr_sr_nxt[7:4] = hx[3:0];
                                state_nxt        = ADDR_LO;
                            end
                            ADDR_LO: begin
                                addr_sr_nxt[3:0] = hx[3:0];
                                state_nxt        = is_write ? DATA_HI : EOL_WAIT;
                            end
                            DATA_HI: begin
                                data_sr_nxt[7:4] = hx[3:0];
                                state_nxt        = DATA_LO;
                            end
                            default: begin
                                data_sr_nxt[3:0] = hx[3:0];
                                state_nxt        = EOL_WAIT;
                            end
                        endcase
                    end else begin
                        // premature EOL already ends the line, so no flush needed
                        err_nxt   = 1'b1;
                        state_nxt = is_eol ? IDLE : FLUSH;
                    end
                end
                EOL_WAIT: begin
                    if (is_eol) begin
                        wr_en_nxt = is_write;
                        rd_en_nxt = !is_write;
                        state_nxt = IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = FLUSH;
                    end
                end
                FLUSH: begin
                    if (is_eol) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (timeout) begin
            err_nxt   = (state != FLUSH);
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            is_write <= 1'b0;
            addr_sr  <= 8'h00;
            data_sr  <= 8'h00;
            wr_en    <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
            rd_en    <= 1'b0;
            rd_addr  <= 8'h00;
            cmd_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            is_write <= is_write_nxt;
            addr_sr  <= addr_sr_nxt;
            data_sr  <= data_sr_nxt;
            wr_en    <= wr_en_nxt;
            rd_en    <= rd_en_nxt;
            cmd_err  <= err_nxt;
            busy     <= (state_nxt != IDLE);
            if (wr_en_nxt) begin
                wr_addr <= addr_sr;
                wr_data <= data_sr;
            end
            if (rd_en_nxt) rd_addr <= addr_sr;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: command strings in, strobe counts and
// latched fields checked against hand-computed values.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       wr_en, rd_en, cmd_err, busy;
    logic [7:0] wr_addr, wr_data, rd_addr;

    int tests = 0, fails = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, multi = 0;
    logic [7:0] last_wa = 8'h00, last_wd = 8'h00, last_ra = 8'h00;

    uart_cmd_parser #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .cmd_err(cmd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin wr_cnt++; last_wa = wr_addr; last_wd = wr_data; end
        if (rd_en) begin rd_cnt++; last_ra = rd_addr; end
        if (cmd_err) err_cnt++;
        if (int'(wr_en) + int'(rd_en) + int'(cmd_err) > 1) multi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        wr_cnt = 0; rd_cnt = 0; err_cnt = 0;
    endtask

    // gap=0 drives bytes on consecutive cycles; returns on the negedge after the last byte
    task automatic send(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            rx_data  = s[i];
            rx_valid = 1'b1;
            if (gap > 0) begin
                @(negedge clk);
                rx_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_rd_addr", rd_addr, 0);
        rst_n = 1'b1;
        settle();

        clr();
        send("W1A5F\015", 0);
        check("w1_latency", wr_en, 1);
        settle();
        check("w1_cnt", wr_cnt, 1);
        check("w1_addr", last_wa, 8'h1A);
        check("w1_data", last_wd, 8'h5F);
        check("w1_err", err_cnt, 0);
        check("w1_busy", busy, 0);

        clr();
        send("rff\015\012", 0);
        settle();
        check("r1_cnt", rd_cnt, 1);
        check("r1_addr", last_ra, 8'hFF);
        check("r1_err", err_cnt, 0);

        clr();
        send("WG1\015", 0);
        settle();
        check("bad_hex_err", err_cnt, 1);
        check("bad_hex_wr", wr_cnt, 0);
        check("bad_hex_busy", busy, 0);
        clr();
        send("R00\012", 0);
        settle();
        check("after_flush_rd", rd_cnt, 1);
        check("after_flush_addr", rd_addr, 8'h00);

        clr();
        send("W12\015", 0);
        settle();
        check("short_err", err_cnt, 1);
        check("short_wr", wr_cnt, 0);
        check("short_busy", busy, 0);
        clr();
        send("R123", 0);
        settle();
        check("long_err", err_cnt, 1);
        check("long_busy_flush", busy, 1);
        send("\015", 0);
        settle();
        check("long_err_once", err_cnt, 1);
        check("long_rd", rd_cnt, 0);
        check("long_busy", busy, 0);

        clr();
        send("W1", 0);
        check("to_busy_pending", busy, 1);
        repeat (90) @(negedge clk);
        check("to_not_early", err_cnt, 0);
        repeat (60) @(negedge clk);
        check("to_err", err_cnt, 1);
        check("to_busy", busy, 0);
        clr();
        send("W0001\015", 0);
        settle();
        check("to_next_wr", wr_cnt, 1);
        check("to_next_addr", last_wa, 8'h00);
        check("to_next_data", last_wd, 8'h01);

        clr();
        send("W1A5", 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        rst_n = 1'b1;
        settle();
        check("mid_rst_no_wr", wr_cnt, 0);
        check("mid_rst_no_err", err_cnt, 0);
        clr();
        send("wAbCd\015", 0);
        settle();
        check("post_rst_wr", wr_cnt, 1);
        check("post_rst_addr", last_wa, 8'hAB);
        check("post_rst_data", last_wd, 8'hCD);

        clr();
        send("r7E\015", 3);
        settle();
        check("gap_rd", rd_cnt, 1);
        check("gap_addr", last_ra, 8'h7E);
        check("gap_err", err_cnt, 0);

        check("strobe_exclusive", multi, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
